serial_loader: RTL and testbench
================================

SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 Parameter WIDTH, default 4: word length in bits, legal range 2..16.
REQ-002 Parameter PRESCALE, default 1: clock cycles per serial bit, legal range 1..256.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port input_clock1_1, in, 1: the single clock; all state changes on its rising edge.
REQ-005 Port input_reset_2, in, 1: asynchronous active-high reset.
REQ-006 Port input_data_3, in, WIDTH: parallel word to send.
REQ-007 Port input_valid_4, in, 1: input_data_3 is valid.
REQ-008 Port output_ready_5, out, 1: a word can be accepted this cycle.
REQ-009 Port output_sdata_6, out, 1: serial data to the downstream shift register's D input.
REQ-010 Port output_shift_7, out, 1: one-cycle strobe; downstream shifts in output_sdata_6 on this cycle.
REQ-011 Port output_latch_8, out, 1: one-cycle strobe; downstream presents its parallel outputs.
REQ-012 Port output_busy_9, out, 1: a frame is in progress.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and LATCH.
REQ-014 IDLE: output_ready_5=1, output_busy_9=0, output_sdata_6=0, both strobes 0.
REQ-015 Accept: on a rising edge in IDLE with input_valid_4=1, capture input_data_3, clear the bit and prescale counters, go to SHIFT.
REQ-016 input_valid_4 outside IDLE SHALL be ignored; no buffering; data need not stay stable after accept.
REQ-017 SHIFT: output_sdata_6 = shadow MSB; the prescale counter runs 0..PRESCALE-1.
REQ-018 output_shift_7 SHALL be 1 exactly in the cycle where the prescale counter equals PRESCALE-1.
REQ-019 On that edge: shadow shifts left by one (zero fill); bit counter increments; prescale counter wraps to 0.
REQ-020 The bit order SHALL be MSB first, so after WIDTH shifts bit 0 sits in the first downstream stage.
REQ-021 After the WIDTH-th strobe the FSM SHALL go to LATCH.
REQ-022 LATCH: output_latch_8=1 for exactly one cycle, output_sdata_6=0, then IDLE unconditionally.
REQ-023 output_busy_9 SHALL be 1 in SHIFT and LATCH.
REQ-024 Timing, accept edge in cycle 0:
- SHIFT spans cycles 1..WIDTH*PRESCALE.
- LATCH is cycle WIDTH*PRESCALE+1.
- output_ready_5 is 1 again in cycle WIDTH*PRESCALE+2.
REQ-025 Back-to-back frames SHALL be gapless apart from the single LATCH cycle and a single IDLE accept cycle.
REQ-026 Bit counter width SHALL be clog2(WIDTH+1); prescale counter width SHALL be max(1, clog2(PRESCALE)); neither may overflow at legal parameter extremes.
REQ-027 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs except input_valid_4 having no effect on output_ready_5.

Reset
REQ-028 Asserting input_reset_2 SHALL immediately force:
- state IDLE, shadow and counters 0;
- output_ready_5=1, output_sdata_6=0, output_shift_7=0, output_latch_8=0, output_busy_9=0.
REQ-029 Reset mid-frame SHALL abort the frame with no further strobes; in particular no output_latch_8 pulse.
REQ-030 The first accept SHALL be possible on the first rising edge after reset deassertion.

Structure
REQ-031 Package serial_loader_pkg SHALL hold the state enumeration (IDLE, SHIFT, LATCH) and the default WIDTH/PRESCALE constants.
REQ-032 The prescale counter and strobe generation SHALL be one sub-module, serial_loader_tick (enable in, tick out, clear in); the FSM and shadow register stay in the top.

Verification
REQ-033 Reset, then no stimulus -> ready=1, busy=0, sdata=shift=latch=0 for 10 cycles.
REQ-034 WIDTH=4, PRESCALE=1, accept 4'b1011 -> sdata 1,0,1,1 in cycles 1..4 with shift=1 each; latch in cycle 5; ready in cycle 6; a model 4-stage shift register then holds 1011.
REQ-035 WIDTH=4, PRESCALE=3, accept 4'b0110 -> shift strobes in cycles 3, 6, 9 and 12; each sdata bit held 3 cycles; latch in cycle 13.
REQ-036 valid held high continuously with 4'hA then 4'h5 -> second accept in cycle 6; 4'hA is not accepted twice; latch pulses in cycles 5 and 11.
REQ-037 Reset asserted in cycle 2 of a frame -> outputs take reset values immediately; no latch pulse; a new accept in the first edge after release works normally.
REQ-038 valid pulsed during SHIFT with a different word -> ignored; the frame in flight completes unchanged.

Source files
------------

// File: rtl/serial_loader_pkg.sv
// Shared types and defaults for the serial loader: FSM state encoding and
// parameter defaults, plus a width helper for the prescale counter.
package serial_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_PRESCALE = 1;

  // A divide-by-one still needs a 1-bit counter so the port stays legal.
  function automatic int ps_width(input int ps);
    return (ps > 1) ? $clog2(ps) : 1;
  endfunction

endpackage

// File: rtl/serial_loader_if.sv
// Word-in / serial-out bus of the serial loader; slave side is the loader.
interface serial_loader_if #(
  parameter int WIDTH = serial_loader_pkg::DEF_WIDTH
);
  logic [WIDTH-1:0] input_data_3;
  logic             input_valid_4;
  logic             output_ready_5;
  logic             output_sdata_6;
  logic             output_shift_7;
  logic             output_latch_8;
  logic             output_busy_9;

  modport master (
    output input_data_3, input_valid_4,
    input  output_ready_5, output_sdata_6, output_shift_7,
    input  output_latch_8, output_busy_9
  );

  modport slave (
    input  input_data_3, input_valid_4,
    output output_ready_5, output_sdata_6, output_shift_7,
    output output_latch_8, output_busy_9
  );
endinterface

// File: rtl/serial_loader_tick.sv
// Bit-period prescaler: counts 0..PRESCALE-1 while enabled and strobes on the
// last count, wrapping to 0 on that same edge.
module serial_loader_tick
  import serial_loader_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic input_clock1_1,
  input  logic input_reset_2,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              PS_W = ps_width(PRESCALE);
  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge input_clock1_1 or posedge input_reset_2) begin
    if (input_reset_2)    cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else if (en)          cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/serial_loader.sv
// Parallel-to-serial loader for an external shift register: shifts a word out
// MSB first with a shift strobe per bit, then pulses latch once.
module serial_loader
  import serial_loader_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic           input_clock1_1,
  input  logic           input_reset_2,
  serial_loader_if.slave bus
);

  localparam int              BC_W     = $clog2(WIDTH + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] shadow, shadow_nxt;
  logic [BC_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic             tick;
  logic             accept;

  assign accept = (state == IDLE) && bus.input_valid_4;

  serial_loader_tick #(.PRESCALE(PRESCALE)) u_tick (
    .input_clock1_1 (input_clock1_1),
    .input_reset_2  (input_reset_2),
    .en             (state == SHIFT),
    .clr            (accept),
    .tick           (tick)
  );

  always_ff @(posedge input_clock1_1 or posedge input_reset_2) begin
    if (input_reset_2) begin
      state   <= IDLE;
      shadow  <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      shadow  <= shadow_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shadow_nxt  = shadow;
    bit_cnt_nxt = bit_cnt;
    case (state)
      IDLE: begin
        if (bus.input_valid_4) begin
          state_nxt   = SHIFT;
          shadow_nxt  = bus.input_data_3;
          bit_cnt_nxt = '0;
        end
      end
      SHIFT: begin
        if (tick) begin
          shadow_nxt  = {shadow[WIDTH-2:0], 1'b0};
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state_nxt = LATCH;
        end
      end
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state only; valid never reaches them.
  assign bus.output_ready_5 = (state == IDLE);
  assign bus.output_busy_9  = (state != IDLE);
  assign bus.output_sdata_6 = (state == SHIFT) && shadow[WIDTH-1];
  assign bus.output_shift_7 = tick;
  assign bus.output_latch_8 = (state == LATCH);

endmodule

// File: tb/tb_serial_loader.sv
// Scoreboard bench for serial_loader: per-cycle expected outputs are queued at
// stimulus time and a negedge monitor compares them, plus a model shift register.
module tb_serial_loader;
  import serial_loader_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_loader_if #(.WIDTH(W)) if0 ();
  serial_loader_if #(.WIDTH(W)) if1 ();

  serial_loader #(.WIDTH(W), .PRESCALE(1)) u0 (
    .input_clock1_1 (clk),
    .input_reset_2  (rst),
    .bus            (if0)
  );

  serial_loader #(.WIDTH(W), .PRESCALE(3)) u1 (
    .input_clock1_1 (clk),
    .input_reset_2  (rst),
    .bus            (if1)
  );

  typedef struct {
    int           cyc;
    logic         ready, sdata, shift, latch, busy;
    logic [W-1:0] word;
  } exp_t;

  exp_t         q0[$];
  exp_t         q1[$];
  int           cyc      = 0;
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] sr0      = '0;
  logic [W-1:0] sr1      = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=%b expected=%b", name, idx, cyc, act, exp);
    end
  endtask

  // Frame timeline relative to the cycle a (cycle 0, the accept cycle).
  task automatic push(input int idx, input int a, input int ps, input logic [W-1:0] word);
    exp_t e;
    for (int k = 1; k <= W * ps + 1; k++) begin
      e.cyc = a + k; e.word = word; e.ready = 1'b0; e.busy = 1'b1;
      if (k <= W * ps) begin
        e.sdata = word[W - 1 - (k - 1) / ps];
        e.shift = ((k % ps) == 0);
        e.latch = 1'b0;
      end else begin
        e.sdata = 1'b0; e.shift = 1'b0; e.latch = 1'b1;
      end
      if (idx == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic mon(input int idx, input logic r, input logic sd, input logic sh,
                     input logic la, input logic bu);
    exp_t         e;
    logic         have;
    logic [W-1:0] sr;
    e    = '{cyc: 0, ready: 1'b1, sdata: 1'b0, shift: 1'b0, latch: 1'b0, busy: 1'b0, word: '0};
    have = 1'b0;
    if (idx == 0) begin
      if (q0.size() > 0 && q0[0].cyc == cyc) begin e = q0.pop_front(); have = 1'b1; end
      sr = sr0;
    end else begin
      if (q1.size() > 0 && q1[0].cyc == cyc) begin e = q1.pop_front(); have = 1'b1; end
      sr = sr1;
    end
    chk("outputs{rdy,sdata,shift,latch,busy}", idx, {3'b0, r, sd, sh, la, bu},
        {3'b0, e.ready, e.sdata, e.shift, e.latch, e.busy});
    if (sh) sr = {sr[W-2:0], sd};
    if (la && have) chk("latched_word", idx, {4'b0, sr}, {4'b0, e.word});
    if (idx == 0) sr0 = sr; else sr1 = sr;
  endtask

  always @(negedge clk) begin
    mon(0, if0.output_ready_5, if0.output_sdata_6, if0.output_shift_7, if0.output_latch_8, if0.output_busy_9);
    mon(1, if1.output_ready_5, if1.output_sdata_6, if1.output_shift_7, if1.output_latch_8, if1.output_busy_9);
  end

  initial begin
    if0.input_valid_4 = 1'b0; if0.input_data_3 = '0;
    if1.input_valid_4 = 1'b0; if1.input_data_3 = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", 0, {3'b0, if0.output_ready_5, if0.output_sdata_6, if0.output_shift_7,
        if0.output_latch_8, if0.output_busy_9}, 8'b0001_0000);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // MSB-first single frame, one cycle per bit
    if0.input_data_3 = 4'b1011; if0.input_valid_4 = 1'b1; push(0, cyc, 1, 4'b1011);
    @(negedge clk); if0.input_valid_4 = 1'b0;
    repeat (8) @(negedge clk);

    // three cycles per bit
    if1.input_data_3 = 4'b0110; if1.input_valid_4 = 1'b1; push(1, cyc, 3, 4'b0110);
    @(negedge clk); if1.input_valid_4 = 1'b0;
    repeat (16) @(negedge clk);

    // valid held high across two frames: second accept at the end of cycle 6
    if0.input_data_3 = 4'hA; if0.input_valid_4 = 1'b1;
    push(0, cyc, 1, 4'hA); push(0, cyc + 6, 1, 4'h5);
    @(negedge clk); if0.input_data_3 = 4'h5;
    repeat (6) @(negedge clk); if0.input_valid_4 = 1'b0;
    repeat (8) @(negedge clk);

    // stray valid with a different word mid-frame is ignored
    if1.input_data_3 = 4'b1001; if1.input_valid_4 = 1'b1; push(1, cyc, 3, 4'b1001);
    @(negedge clk); if1.input_valid_4 = 1'b0;
    repeat (3) @(negedge clk);
    if1.input_data_3 = 4'b0110; if1.input_valid_4 = 1'b1;
    @(negedge clk); if1.input_valid_4 = 1'b0;
    repeat (14) @(negedge clk);

    // reset during cycle 2 of a frame aborts it without a latch
    if0.input_data_3 = 4'b1100; if0.input_valid_4 = 1'b1; push(0, cyc, 1, 4'b1100);
    @(negedge clk); if0.input_valid_4 = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1; q0.delete();
    #1;
    chk("reset_midframe", 0, {3'b0, if0.output_ready_5, if0.output_sdata_6, if0.output_shift_7,
        if0.output_latch_8, if0.output_busy_9}, 8'b0001_0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    if0.input_data_3 = 4'b0011; if0.input_valid_4 = 1'b1; push(0, cyc, 1, 4'b0011);
    @(negedge clk); if0.input_valid_4 = 1'b0;
    repeat (8) @(negedge clk);

    chk("pending_expectations", 0, 8'(q0.size() + q1.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
